// File: rtl/md_phase_sequencer.sv
// Timestep initiator for the MD accelerator.
// Each timestep hands the force phase (phase 1) and then the motion-update
// phase (phase 2) a CTL_READY request, waits for each CTL_DONE handshake,
// then flips the double-buffer select. It repeats for n_steps timesteps.
// The handshake outputs are registered and follow the FSM by one cycle.
// A ready drops on the same cycle the FSM leaves its phase, so there is
// always a gap cycle with both readies low between phases.
module md_phase_sequencer #(
  parameter int STEP_W      = 32,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [STEP_W-1:0] n_steps,
  output logic              p1_ready,
  input  logic              p1_done,
  output logic              p2_ready,
  input  logic              p2_done,
  output logic              double_buffer,
  output logic [1:0]        phase,
  output logic [STEP_W-1:0] step_count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, P1_ACK, P1_RUN, P2_ACK, P2_RUN, STEP_END, FINISH
  } state_t;

  state_t            state, nxt;
  logic [STEP_W-1:0] target;
  logic [TW-1:0]     to_cnt;
  logic [STEP_W-1:0] step_inc;
  logic              accept;
  logic              to_hit;
  logic              in_p1, in_p2, nxt_p1, nxt_p2;
  logic              ack_enter, ack_wait;

  // busy stays high through the done cycle, so a start there is ignored
  assign accept   = (state == IDLE) && start && !busy;
  assign step_inc = step_count + STEP_W'(1);
  assign to_hit   = (to_cnt == TW'(ACK_TIMEOUT - 1));

  assign in_p1  = (state == P1_ACK) || (state == P1_RUN);
  assign in_p2  = (state == P2_ACK) || (state == P2_RUN);
  assign nxt_p1 = (nxt == P1_ACK) || (nxt == P1_RUN);
  assign nxt_p2 = (nxt == P2_ACK) || (nxt == P2_RUN);

  // timeout counter restarts on each fresh entry into an ACK state
  assign ack_enter = ((nxt == P1_ACK) || (nxt == P2_ACK)) && (nxt != state);
  // cycles still waiting for the done drop
  assign ack_wait  = ((state == P1_ACK) && p1_done) || ((state == P2_ACK) && p2_done);

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (accept) nxt = (n_steps == '0) ? FINISH : P1_ACK;
      P1_ACK:   if (!p1_done) nxt = P1_RUN;
                else if (to_hit) nxt = FINISH;
      P1_RUN:   if (p1_done) nxt = P2_ACK;
      P2_ACK:   if (!p2_done) nxt = P2_RUN;
                else if (to_hit) nxt = FINISH;
      P2_RUN:   if (p2_done) nxt = STEP_END;
      STEP_END: nxt = (step_inc == target) ? FINISH : P1_ACK;
      FINISH:   nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // ack timeout counter; saturates so a timed-out ACK is visible in FINISH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             to_cnt <= '0;
    else if (accept || ack_enter)           to_cnt <= '0;
    else if (ack_wait && (to_cnt != TW'(ACK_TIMEOUT))) to_cnt <= to_cnt + TW'(1);
  end

  // registered handshake and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_ready      <= 1'b0;
      p2_ready      <= 1'b0;
      phase         <= 2'd0;
      double_buffer <= 1'b0;
      step_count    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      target        <= '0;
    end else begin
      // ready is high only while both this and the next cycle sit in the phase
      p1_ready <= in_p1 && nxt_p1;
      p2_ready <= in_p2 && nxt_p2;
      phase    <= (in_p1 && nxt_p1) ? 2'd1 : (in_p2 && nxt_p2) ? 2'd2 : 2'd0;
      done     <= (state == FINISH);

      if (state == STEP_END) begin
        step_count    <= step_inc;
        double_buffer <= ~double_buffer;
      end else if (accept) begin
        step_count    <= '0;
      end

      if (accept)    busy <= 1'b1;
      else if (done) busy <= 1'b0;

      if (accept) error <= 1'b0;
      else if ((state == FINISH) && (to_cnt == TW'(ACK_TIMEOUT))) error <= 1'b1;

      if (accept) target <= n_steps;
    end
  end

endmodule

// File: tb/tb_md_phase_sequencer.sv
// Bench for md_phase_sequencer: phase agents with fixed or random handshake
// latencies, run-level expectations derived from the step count, and
// per-cycle invariants on ready exclusivity and double-buffer stability.
module tb_md_phase_sequencer;
  localparam int STEP_W      = 32;
  localparam int ACK_TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [STEP_W-1:0] n_steps = '0;
  logic              p1_done = 1'b1;
  logic              p2_done = 1'b1;
  logic              p1_ready, p2_ready, double_buffer, busy, done, error;
  logic [1:0]        phase;
  logic [STEP_W-1:0] step_count;

  int   n_chk = 0;
  int   n_pass = 0;
  logic db_model = 1'b0;

  // agent configuration
  bit stuck1   = 1'b0;
  bit rnd_lat  = 1'b0;
  int fix_drop = 2;
  int fix_run  = 10;

  // monitor counters
  int   p1_rise = 0, p2_rise = 0, done_cnt = 0, db_tog = 0;
  logic p1_q = 1'b0, p2_q = 1'b0, db_q = 1'b0, rst_q = 1'b0;

  always #5 clk = ~clk;

  md_phase_sequencer #(.STEP_W(STEP_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .n_steps(n_steps),
    .p1_ready(p1_ready), .p1_done(p1_done),
    .p2_ready(p2_ready), .p2_done(p2_done),
    .double_buffer(double_buffer), .phase(phase), .step_count(step_count),
    .busy(busy), .done(done), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // phase agents: drop done some cycles after ready, raise it again later
  initial begin : agents
    int st [2];
    int cnt [2];
    logic r;
    st[0] = 0; st[1] = 0; cnt[0] = 0; cnt[1] = 0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        r = (k == 0) ? p1_ready : p2_ready;
        case (st[k])
          0: if (r && !(k == 0 && stuck1)) begin
               st[k] = 1;
               cnt[k] = rnd_lat ? int'($urandom_range(1, 4)) : fix_drop;
             end
          1: if (!r) st[k] = 0;
             else begin
               cnt[k]--;
               if (cnt[k] <= 0) begin
                 if (k == 0) p1_done = 1'b0; else p2_done = 1'b0;
                 st[k] = 2;
                 cnt[k] = rnd_lat ? int'($urandom_range(1, 6)) : fix_run;
               end
             end
          2: if (!r) begin
               if (k == 0) p1_done = 1'b1; else p2_done = 1'b1;
               st[k] = 0;
             end else begin
               cnt[k]--;
               if (cnt[k] <= 0) begin
                 if (k == 0) p1_done = 1'b1; else p2_done = 1'b1;
                 st[k] = 3;
               end
             end
          default: if (!r) st[k] = 0;
        endcase
      end
    end
  end

  // invariants and event counting, sampled mid-cycle
  always @(negedge clk) begin
    if (reset && rst_q) begin
      chk("ready_excl", 32'(p1_ready & p2_ready), 32'd0);
      chk("db_quiet", 32'((double_buffer != db_q) & (p1_ready | p2_ready | p1_q | p2_q)), 32'd0);
      if (p1_ready && !p1_q) p1_rise <= p1_rise + 1;
      if (p2_ready && !p2_q) p2_rise <= p2_rise + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (double_buffer != db_q) db_tog <= db_tog + 1;
    end
    p1_q  <= p1_ready;
    p2_q  <= p2_ready;
    db_q  <= double_buffer;
    rst_q <= reset;
  end

  task automatic wait_done(input string tag, input int bound, output int lat, output bit seen);
    seen = 1'b0;
    lat  = 1;
    while (!seen && lat < bound) begin
      @(posedge clk); #1;
      lat++;
      seen = done;
    end
    chk({tag, ":done_seen"}, 32'(seen), 32'd1);
  endtask

  // one run from start to done, checked against step-count arithmetic
  task automatic run(input logic [STEP_W-1:0] n, input bit exp_to, input string tag);
    int p1b, p2b, dnb, dbb, lat;
    bit seen;
    logic [31:0] steps_exp;
    p1b = p1_rise; p2b = p2_rise; dnb = done_cnt; dbb = db_tog;
    n_steps = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_steps = $urandom;
    chk({tag, ":busy_on"}, 32'(busy), 32'd1);
    chk({tag, ":err_clr"}, 32'(error), 32'd0);
    chk({tag, ":sc_clr"}, step_count, 32'd0);
    wait_done(tag, 60 * int'(n) + 200, lat, seen);
    if (n == 0) chk({tag, ":lat0"}, 32'(lat), 32'd2);
    if (exp_to) chk({tag, ":lat_to"}, 32'(lat), 32'(ACK_TIMEOUT + 2));
    steps_exp = exp_to ? 32'd0 : n;
    chk({tag, ":steps"}, step_count, steps_exp);
    chk({tag, ":error"}, 32'(error), 32'(exp_to));
    if (!exp_to) db_model = db_model ^ n[0];
    chk({tag, ":dbuf"}, 32'(double_buffer), 32'(db_model));
    @(posedge clk); #1;
    chk({tag, ":busy_off"}, 32'(busy), 32'd0);
    chk({tag, ":done_pulse"}, 32'(done), 32'd0);
    chk({tag, ":p1_reqs"}, 32'(p1_rise - p1b), exp_to ? 32'd1 : n);
    chk({tag, ":p2_reqs"}, 32'(p2_rise - p2b), steps_exp);
    chk({tag, ":done_cnt"}, 32'(done_cnt - dnb), 32'd1);
    chk({tag, ":db_tog"}, 32'(db_tog - dbb), steps_exp);
    if (exp_to) chk({tag, ":p1_low"}, 32'(p1_ready), 32'd0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    bit seen;
    // reset state
    #1;
    chk("rst:p1_ready", 32'(p1_ready), 32'd0);
    chk("rst:p2_ready", 32'(p2_ready), 32'd0);
    chk("rst:dbuf", 32'(double_buffer), 32'd0);
    chk("rst:phase", 32'(phase), 32'd0);
    chk("rst:steps", step_count, 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:error", 32'(error), 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // directed runs with fixed phase latencies
    run(32'd3, 1'b0, "n3");
    run(32'd0, 1'b0, "n0");
    stuck1 = 1'b1;
    run(32'd5, 1'b1, "tmo");
    stuck1 = 1'b0;
    run(32'd1, 1'b0, "after_tmo");

    // start during busy and in the done cycle are ignored
    n_steps = 32'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_steps = 32'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done("ign", 300, lat, seen);
    chk("ign:steps", step_count, 32'd1);
    n_steps = 32'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("ign:done_cycle_busy", 32'(busy), 32'd0);
    n_steps = 32'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("ign:next_busy", 32'(busy), 32'd1);
    chk("ign:next_sc", step_count, 32'd0);
    wait_done("ign2", 300, lat, seen);
    chk("ign2:steps", step_count, 32'd2);
    db_model = db_model ^ 1'b1;
    chk("ign2:dbuf", 32'(double_buffer), 32'(db_model));
    @(posedge clk); #1;

    // reset during phase 2 of the second timestep
    n_steps = 32'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0;
    while (!(step_count == 32'd1 && p2_ready && !p2_done) && lat < 400) begin
      @(posedge clk); #1; lat++;
    end
    chk("mid:reached_p2run", 32'(lat < 400), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid:p1_ready", 32'(p1_ready), 32'd0);
    chk("mid:p2_ready", 32'(p2_ready), 32'd0);
    chk("mid:dbuf", 32'(double_buffer), 32'd0);
    chk("mid:phase", 32'(phase), 32'd0);
    chk("mid:steps", step_count, 32'd0);
    chk("mid:busy", 32'(busy), 32'd0);
    chk("mid:done", 32'(done), 32'd0);
    chk("mid:error", 32'(error), 32'd0);
    db_model = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run(32'd2, 1'b0, "post_rst");

    // random latencies and run lengths
    rnd_lat = 1'b1;
    for (int i = 0; i < 6; i++) run(32'($urandom_range(0, 7)), 1'b0, "rnd");
    run(32'd100, 1'b0, "long100");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
